perceptron_uart_n: RTL and testbench

Parametrised UART-attached perceptron: a host writes N signed weights, a bias and N signed inputs over a serial link, then requests evaluation or one online training step. The block replies with bytes on its own serial output. It is the generalised successor of the fixed single-perceptron UART block: input count, data width and baud divisor are configurable, and on-chip training is added. It sits directly on the board UART pins.

---
 rtl/perceptron_pkg.sv | 14 +
 rtl/perceptron_uart_n_if.sv | 7 +
 rtl/uart_serdes.sv | 84 ++++++++
 rtl/perceptron_uart_n.sv | 99 +++++++++
 tb/tb_perceptron_uart_n.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_pkg.sv
// perceptron_pkg: opcodes, state encodings and saturation helper shared by the perceptron UART block
package perceptron_pkg;
  localparam logic [1:0] OP_WR_W = 2'b00;
  localparam logic [1:0] OP_WR_X = 2'b01;
  localparam logic [1:0] OP_EVAL = 2'b10;
  localparam logic [1:0] OP_TRAIN = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_GET_DATA, S_MAC, S_CMP, S_UPDATE, S_SEND} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  function automatic int sat_to(input int width, input int value);
    int hi;
    hi = (1 << (width - 1)) - 1;
    return value > hi ? hi : value < -hi - 1 ? -hi - 1 : value;
  endfunction
endpackage

// File: rtl/perceptron_uart_n_if.sv
// perceptron_uart_n_if: board UART pin pair between host and perceptron
interface perceptron_uart_n_if;
  logic host_tx;
  logic uart_tx;
  modport master(output host_tx, input uart_tx);
  modport slave(input host_tx, output uart_tx);
endinterface

// File: rtl/uart_serdes.sv
// uart_serdes: 8N1 byte receiver and transmitter at CLKS_PER_BIT clocks per bit
module uart_serdes import perceptron_pkg::*; #(
  parameter int CLKS_PER_BIT = 430
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  output logic       tx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_t rx_st;
  logic [2:0] sync;
  logic [CW-1:0] rc, tc;
  logic [2:0] rn;
  logic [3:0] tn;
  logic [9:0] sh;
  logic tx_act;
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_st <= RX_IDLE;
      sync <= 3'b111;
      rc <= '0;
      rn <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx};
      rx_valid <= 1'b0;
      rc <= rc + 1'b1;
      case (rx_st)
        RX_IDLE: begin
          rc <= '0;
          if (sync[2] && !sync[1]) rx_st <= RX_START;
        end
        RX_START: if (rc == HALF) begin
          rc <= '0;
          rn <= '0;
          rx_st <= sync[1] ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rc == FULL) begin
          rc <= '0;
          rx_byte <= {sync[1], rx_byte[7:1]};
          rn <= rn + 1'b1;
          if (rn == 3'd7) rx_st <= RX_STOP;
        end
        RX_STOP: if (rc == FULL) begin
          rx_st <= RX_IDLE;
          rx_valid <= sync[1];
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end
  // ready already in the last stop-bit cycle so a queued byte follows with no gap
  assign tx_busy = tx_act && !(tc == FULL && tn == 4'd9);
  assign tx = sh[0];
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sh <= '1;
      tc <= '0;
      tn <= '0;
      tx_act <= 1'b0;
    end else if (tx_start && !tx_busy) begin
      sh <= {1'b1, tx_byte, 1'b0};
      tc <= '0;
      tn <= '0;
      tx_act <= 1'b1;
    end else if (tx_act) begin
      tc <= tc == FULL ? '0 : tc + 1'b1;
      if (tc == FULL) begin
        tn <= tn + 1'b1;
        sh <= {1'b1, sh[9:1]};
        tx_act <= tn != 4'd9;
      end
    end
  end
endmodule

// File: rtl/perceptron_uart_n.sv
// perceptron_uart_n: UART-attached N-input perceptron with evaluation and online training
module perceptron_uart_n import perceptron_pkg::*; #(
  parameter int CLKS_PER_BIT = 430,
  parameter int N_INPUTS = 4,
  parameter int W = 8,
  parameter int LR_SHIFT = 2
) (
  input logic clk,
  input logic nRst,
  perceptron_uart_n_if.slave bus
);
  localparam int IW = $clog2(N_INPUTS + 1);
  localparam int AW = 2 * W + IW;
  localparam int PW = 2 * W;
  localparam logic [IW-1:0] LAST = IW'(N_INPUTS - 1);
  localparam logic [IW-1:0] NB = IW'(N_INPUTS);
  state_t state, nxt;
  logic signed [W-1:0] wt [2**IW];
  logic signed [W-1:0] x [2**IW];
  logic [1:0] op, sent, nrep;
  logic [5:0] idx;
  logic [IW-1:0] i;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] prod;
  logic signed [W-1:0] upd;
  logic mis, rx_valid, tx_start, tx_busy, tx_load;
  logic [7:0] rx_byte, tx_byte;
  int delta;
  uart_serdes #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_serdes (
    .clk(clk), .nRst(nRst), .rx(bus.host_tx), .tx(bus.uart_tx),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_start(tx_start), .tx_byte(tx_byte), .tx_busy(tx_busy)
  );
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (rx_valid) nxt = rx_byte[7] ? S_MAC : S_GET_DATA;
      S_GET_DATA: if (rx_valid) nxt = S_IDLE;
      S_MAC: if (i == LAST) nxt = op == OP_EVAL ? S_SEND : S_CMP;
      S_CMP: nxt = S_UPDATE;
      S_UPDATE: if (i == NB) nxt = S_SEND;
      S_SEND: if (sent == nrep && !tx_busy) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  // slot NB of the weight array is the bias; its training step is always 1
  always_comb begin
    nrep = op == OP_EVAL ? 2'd2 : 2'd1;
    tx_start = state == S_SEND && sent != nrep;
    tx_load = tx_start && !tx_busy;
    tx_byte = op == OP_TRAIN ? {7'd0, mis} : sent == 2'd0 ? 8'(sat_to(8, int'(acc))) : {7'd0, !acc[AW-1]};
    prod = PW'(wt[i]) * PW'(x[i]);
    delta = i == NB ? 1 : int'(x[i]) >>> LR_SHIFT;
    upd = W'(sat_to(W, int'(wt[i]) + (idx[0] ? delta : -delta)));
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int k = 0; k < 2**IW; k++) begin
        wt[k] <= '0;
        x[k] <= '0;
      end
      op <= '0;
      idx <= '0;
      i <= '0;
      acc <= '0;
      mis <= 1'b0;
      sent <= '0;
    end else begin
      case (state)
        S_IDLE: if (rx_valid) begin
          op <= rx_byte[7:6];
          idx <= rx_byte[5:0];
          acc <= AW'(wt[NB]);
          i <= '0;
          sent <= '0;
        end
        S_GET_DATA: if (rx_valid) begin
          if (op == OP_WR_W && idx <= 6'(N_INPUTS)) wt[idx[IW-1:0]] <= rx_byte[W-1:0];
          if (op == OP_WR_X && idx < 6'(N_INPUTS)) x[idx[IW-1:0]] <= rx_byte[W-1:0];
        end
        S_MAC: begin
          acc <= acc + AW'(prod);
          i <= i == LAST ? '0 : i + 1'b1;
        end
        S_CMP: mis <= !acc[AW-1] != idx[0];
        S_UPDATE: begin
          if (mis) wt[i] <= upd;
          i <= i + 1'b1;
        end
        S_SEND: if (tx_load) sent <= sent + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_uart_n.sv
// tb_perceptron_uart_n: serial-level self-checking bench with an arithmetic perceptron reference model
module tb_perceptron_uart_n;
  localparam int CPB = 12, N = 4, W = 8, LR = 2;
  typedef struct {logic [7:0] b; int t;} rx_t;
  logic clk = 1'b0;
  logic nRst;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int mw [N+1];
  int mx [N];
  rx_t q [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  perceptron_uart_n_if bus();
  perceptron_uart_n #(.CLKS_PER_BIT(CPB), .N_INPUTS(N), .W(W), .LR_SHIFT(LR)) dut (
    .clk(clk), .nRst(nRst), .bus(bus)
  );

  initial begin : mon
    logic [7:0] b;
    int t;
    rx_t r;
    forever begin
      @(negedge bus.uart_tx);
      t = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        repeat (CPB) @(negedge clk);
        b[j] = bus.uart_tx;
      end
      repeat (CPB) @(negedge clk);
      r.b = b;
      r.t = t;
      q.push_back(r);
    end
  end

  function automatic int clamp(int v, int bits);
    int hi;
    hi = (1 << (bits - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction
  function automatic int sx(logic [7:0] d);
    int v;
    v = int'(d) & ((1 << W) - 1);
    return v >= (1 << (W - 1)) ? v - (1 << W) : v;
  endfunction
  function automatic int msum();
    int s;
    s = mw[N];
    for (int k = 0; k < N; k++) s += mw[k] * mx[k];
    return s;
  endfunction
  function automatic logic [7:0] esum(int s);
    return 8'(clamp(s, 8));
  endfunction
  function automatic logic [7:0] ecls(int s);
    return s >= 0 ? 8'h01 : 8'h00;
  endfunction
  function automatic logic [7:0] mtrain(bit t);
    int d;
    if ((msum() >= 0) == t) return 8'h00;
    for (int k = 0; k < N; k++) begin
      d = mx[k] >>> LR;
      mw[k] = clamp(mw[k] + (t ? d : -d), W);
    end
    mw[N] = clamp(mw[N] + (t ? 1 : -1), W);
    return 8'h01;
  endfunction
  function automatic void model_clear();
    for (int k = 0; k <= N; k++) mw[k] = 0;
    for (int k = 0; k < N; k++) mx[k] = 0;
  endfunction

  task automatic bit_out(logic v);
    bus.host_tx = v;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send_byte(logic [7:0] b, bit stop = 1'b1, int idle = 1);
    bit_out(1'b0);
    for (int j = 0; j < 8; j++) bit_out(b[j]);
    bit_out(stop);
    repeat (idle) bit_out(1'b1);
  endtask
  task automatic wr_w(int id, logic [7:0] d, int idle = 1);
    send_byte({2'b00, 6'(id)}, 1'b1, idle);
    send_byte(d, 1'b1, idle);
    if (id <= N) mw[id] = sx(d);
  endtask
  task automatic wr_x(int id, logic [7:0] d, int idle = 1);
    send_byte({2'b01, 6'(id)}, 1'b1, idle);
    send_byte(d, 1'b1, idle);
    if (id < N) mx[id] = sx(d);
  endtask
  task automatic get_byte(output logic [7:0] b, output int t);
    rx_t r;
    int k;
    k = 0;
    while (q.size() == 0 && k < 40 * CPB) begin
      @(negedge clk);
      k++;
    end
    if (q.size() == 0) begin
      b = 8'hxx;
      t = -1;
    end else begin
      r = q.pop_front();
      b = r.b;
      t = r.t;
    end
  endtask
  task automatic do_eval(output logic [7:0] b0, output logic [7:0] b1, output int gap);
    int t0, t1;
    send_byte(8'h80);
    get_byte(b0, t0);
    get_byte(b1, t1);
    gap = (t0 < 0 || t1 < 0) ? -1 : t1 - t0;
  endtask
  task automatic quiet(output int n);
    repeat (25 * CPB) @(negedge clk);
    n = q.size();
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (4) @(negedge clk);
    model_clear();
    q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] b0, b1;
    int gap, k;
    nRst = 1'b0;
    bus.host_tx = 1'b1;
    model_clear();
    repeat (4) @(negedge clk);
    n_tests++;
    if (bus.uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b, expected 1", bus.uart_tx); end
    nRst = 1'b1;
    repeat (4) @(negedge clk);
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== 8'h00) begin n_fail++; $display("FAIL reset_eval_sum: got %h, expected 00", b0); end
    n_tests++;
    if (b1 !== 8'h01) begin n_fail++; $display("FAIL reset_eval_class: got %h, expected 01", b1); end
    wr_w(0, 8'h05);
    wr_x(0, 8'h03);
    send_byte(8'h80);
    k = 0;
    while (bus.uart_tx !== 1'b0 && k < 40 * CPB) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_tests++;
    if (bus.uart_tx !== 1'b0) begin n_fail++; $display("FAIL reset_midframe_low: got %b, expected 0", bus.uart_tx); end
    nRst = 1'b0;
    #1;
    n_tests++;
    if (bus.uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_async_tx: got %b, expected 1", bus.uart_tx); end
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (30 * CPB) @(negedge clk);
    q.delete();
    model_clear();
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== 8'h00) begin n_fail++; $display("FAIL reset_clears_sum: got %h, expected 00", b0); end
    n_tests++;
    if (b1 !== 8'h01) begin n_fail++; $display("FAIL reset_clears_class: got %h, expected 01", b1); end
  endtask

  task automatic test_basic_eval();
    logic [7:0] b0, b1;
    int gap;
    wr_w(0, 8'h03);
    wr_w(1, 8'hFE);
    wr_x(0, 8'h05);
    wr_x(1, 8'h04);
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== 8'h07) begin n_fail++; $display("FAIL basic_sum: got %h, expected 07", b0); end
    n_tests++;
    if (b1 !== 8'h01) begin n_fail++; $display("FAIL basic_class: got %h, expected 01", b1); end
    n_tests++;
    if (gap !== 10 * CPB) begin n_fail++; $display("FAIL basic_reply_gap: got %0d, expected %0d", gap, 10 * CPB); end
  endtask

  task automatic test_saturation();
    logic [7:0] b0, b1;
    int gap;
    wr_w(0, 8'h7F);
    wr_w(1, 8'h7F);
    wr_x(0, 8'h7F);
    wr_x(1, 8'h7F);
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== 8'h7F) begin n_fail++; $display("FAIL sat_pos_sum: got %h, expected 7f", b0); end
    n_tests++;
    if (b1 !== 8'h01) begin n_fail++; $display("FAIL sat_pos_class: got %h, expected 01", b1); end
    wr_w(N, 8'h80);
    for (int k = 0; k < N; k++) begin
      wr_w(k, 8'h80);
      wr_x(k, 8'h7F);
    end
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== 8'h80) begin n_fail++; $display("FAIL sat_neg_sum: got %h, expected 80", b0); end
    n_tests++;
    if (b1 !== 8'h00) begin n_fail++; $display("FAIL sat_neg_class: got %h, expected 00", b1); end
  endtask

  task automatic test_train();
    logic [7:0] b, b0, b1, e;
    int t, gap;
    pulse_reset();
    wr_x(0, 8'h10);
    send_byte(8'hC0);
    e = mtrain(1'b0);
    get_byte(b, t);
    n_tests++;
    if (b !== 8'h01) begin n_fail++; $display("FAIL train_update_reply: got %h, expected 01", b); end
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== 8'hBF) begin n_fail++; $display("FAIL train_eval_sum: got %h, expected bf", b0); end
    n_tests++;
    if (b1 !== 8'h00) begin n_fail++; $display("FAIL train_eval_class: got %h, expected 00", b1); end
    send_byte(8'hC0);
    e = mtrain(1'b0);
    get_byte(b, t);
    n_tests++;
    if (b !== 8'h00) begin n_fail++; $display("FAIL train_no_update_reply: got %h, expected 00 (model %h)", b, e); end
  endtask

  task automatic test_robust();
    logic [7:0] b0, b1;
    int gap, n, s;
    wr_x(5, 8'h33);
    wr_w(6, 8'h44);
    quiet(n);
    n_tests++;
    if (n !== 0) begin n_fail++; $display("FAIL oor_no_reply: got %0d bytes, expected 0", n); end
    s = msum();
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== esum(s)) begin n_fail++; $display("FAIL oor_eval_sum: got %h, expected %h", b0, esum(s)); end
    send_byte(8'h80, 1'b0, 2);
    quiet(n);
    n_tests++;
    if (n !== 0) begin n_fail++; $display("FAIL framing_dropped: got %0d bytes, expected 0", n); end
    send_byte(8'h00);
    send_byte(8'h55, 1'b0, 2);
    send_byte(8'h11);
    mw[0] = sx(8'h11);
    s = msum();
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== esum(s)) begin n_fail++; $display("FAIL framing_data_sum: got %h, expected %h", b0, esum(s)); end
    n_tests++;
    if (b1 !== ecls(s)) begin n_fail++; $display("FAIL framing_data_class: got %h, expected %h", b1, ecls(s)); end
    send_byte(8'h80, 1'b1, 0);
    send_byte(8'h80);
    get_byte(b0, gap);
    get_byte(b1, gap);
    n_tests++;
    if (b0 !== esum(s)) begin n_fail++; $display("FAIL busy_first_reply: got %h, expected %h", b0, esum(s)); end
    quiet(n);
    n_tests++;
    if (n !== 0) begin n_fail++; $display("FAIL busy_cmd_dropped: got %0d extra bytes, expected 0", n); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    int gap, s;
    for (int k = 0; k <= N; k++) wr_w(k, 8'($urandom), 0);
    for (int k = 0; k < N; k++) wr_x(k, 8'($urandom), 0);
    s = msum();
    do_eval(b0, b1, gap);
    n_tests++;
    if (b0 !== esum(s)) begin n_fail++; $display("FAIL b2b_sum: got %h, expected %h", b0, esum(s)); end
    n_tests++;
    if (b1 !== ecls(s)) begin n_fail++; $display("FAIL b2b_class: got %h, expected %h", b1, ecls(s)); end
    n_tests++;
    if (gap !== 10 * CPB) begin n_fail++; $display("FAIL b2b_reply_gap: got %0d, expected %0d", gap, 10 * CPB); end
  endtask

  task automatic test_random();
    logic [7:0] b, b0, b1, e, d;
    int gap, s, nw, id, t;
    bit tg;
    for (int it = 0; it < 8; it++) begin
      nw = $urandom_range(1, 6);
      for (int j = 0; j < nw; j++) begin
        id = $urandom_range(0, N + 2);
        d = 8'($urandom);
        if ($urandom_range(0, 1) == 1) wr_w(id, d);
        else wr_x(id, d);
      end
      if ($urandom_range(0, 1) == 1) begin
        tg = 1'($urandom_range(0, 1));
        send_byte({7'b1100000, tg});
        e = mtrain(tg);
        get_byte(b, t);
        n_tests++;
        if (b !== e) begin n_fail++; $display("FAIL rand_train_%0d: got %h, expected %h", it, b, e); end
      end
      s = msum();
      do_eval(b0, b1, gap);
      n_tests++;
      if (b0 !== esum(s)) begin n_fail++; $display("FAIL rand_sum_%0d: got %h, expected %h", it, b0, esum(s)); end
      n_tests++;
      if (b1 !== ecls(s)) begin n_fail++; $display("FAIL rand_class_%0d: got %h, expected %h", it, b1, ecls(s)); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_eval();
    test_saturation();
    test_train();
    test_robust();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
